// File: rtl/dm_access_ctrl_pkg.sv
// dm_access_ctrl_pkg: size codes, FSM states and alignment helper for the data-memory access controller
package dm_access_ctrl_pkg;
    localparam int ADDR_LSB = 2;
    localparam int ADDR_MSB = 11;
    localparam int AW = ADDR_MSB - ADDR_LSB + 1;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    typedef enum logic {ST_IDLE, ST_MERGE} state_e;
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return size == 2'b11 || (size == SIZE_HALF && off[0]) || (size == SIZE_WORD && off != 2'b00);
    endfunction
endpackage

// File: rtl/dm_access_ctrl_lane_unit.sv
// dm_access_ctrl_lane_unit: load lane extract/extend and store lane insert into a memory word
module dm_access_ctrl_lane_unit
    import dm_access_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        signext,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        load_data = size == SIZE_BYTE ? {{24{signext & b[7]}}, b} :
                    size == SIZE_HALF ? {{16{signext & h[15]}}, h} : word;
        merged = word;
        if (size == SIZE_BYTE)
            merged[{off, 3'b000} +: 8] = wdata[7:0];
        else
            merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
    end
endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: MEM-stage data-memory initiator with read-modify-write for sub-word stores
module dm_access_ctrl
    import dm_access_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_signext,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          busy,
    output logic [31:0]   rdata,
    output logic          rdata_valid,
    output logic          fault,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_din,
    output logic          dm_wr,
    input  logic [31:0]   dm_dout
);
    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   merge_q, merge_d, rdata_q, rdata_d;
    logic          rdata_valid_q, rdata_valid_d, fault_q, fault_d;
    logic          idle, bad, go, is_ld, is_sw, is_sub;
    logic [31:0]   load_data, merged;
    logic          addr_hi_unused;

    assign addr_hi_unused = ^req_addr[31:ADDR_MSB+1];

    dm_access_ctrl_lane_unit u_lane (
        .size      (req_size),
        .signext   (req_signext),
        .off       (req_addr[1:0]),
        .word      (dm_dout),
        .wdata     (req_wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    // reset in the MERGE cycle must suppress the pending write, hence the rst terms
    always_comb begin
        idle          = state_q == ST_IDLE;
        bad           = misaligned(req_size, req_addr[1:0]);
        go            = req_valid & idle & ~rst;
        is_ld         = go & ~bad & ~req_we;
        is_sw         = go & ~bad & req_we & (req_size == SIZE_WORD);
        is_sub        = go & ~bad & req_we & (req_size != SIZE_WORD);
        busy          = is_sub;
        dm_wr         = is_sw | (~idle & ~rst);
        dm_addr       = idle ? req_addr[ADDR_MSB:ADDR_LSB] : addr_q;
        dm_din        = is_sw ? req_wdata : dm_wr ? merge_q : '0;
        state_d       = is_sub ? ST_MERGE : ST_IDLE;
        addr_d        = is_sub ? req_addr[ADDR_MSB:ADDR_LSB] : addr_q;
        merge_d       = is_sub ? merged : merge_q;
        rdata_d       = is_ld ? load_data : rdata_q;
        rdata_valid_d = is_ld;
        fault_d       = go & bad;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            merge_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            merge_q       <= merge_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            fault_q       <= fault_d;
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign fault       = fault_q;
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: table vectors, corner sequences and random traffic against a byte-array memory model
module tb_dm_access_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_signext = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        busy, rdata_valid, fault, dm_wr;
    logic [31:0] rdata, dm_din, dm_dout;
    logic [9:0]  dm_addr;
    logic [31:0] dm [0:1023] = '{default: 32'h0};
    logic [7:0]  mb [0:4095] = '{default: 8'h0};
    int total = 0, passed = 0;

    dm_access_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_signext(req_signext), .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy),
        .rdata(rdata), .rdata_valid(rdata_valid), .fault(fault), .dm_addr(dm_addr),
        .dm_din(dm_din), .dm_wr(dm_wr), .dm_dout(dm_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (dm_wr) dm[dm_addr] <= dm_din;
    assign dm_dout = dm[dm_addr];

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] mword(input int w);
        return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
    endfunction

    task automatic model(input logic we, input logic [1:0] size, input logic sx, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] erd, output logic erv,
                         output logic eflt, output int ebc, output int ewc);
        int a, n;
        logic [31:0] v;
        a = int'(addr[11:0]);
        eflt = size == 2'd3 || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
        erd = '0; erv = 1'b0; ebc = 0; ewc = 0;
        if (!eflt) begin
            n = 1 << size;
            if (we) begin
                for (int i = 0; i < n; i++) mb[a+i] = wdata[8*i +: 8];
                ewc = 1;
                ebc = (n < 4) ? 1 : 0;
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mb[a+i];
                if (sx && n < 4 && v[8*n-1])
                    for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
                erd = v;
                erv = 1'b1;
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sx, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd, output logic rv,
                          output logic flt, output int bc, output int wc);
        logic b;
        req_valid = 1'b1; req_we = we; req_size = size; req_signext = sx;
        req_addr = addr; req_wdata = wdata;
        bc = 0; wc = 0; rd = '0; rv = 1'b0; flt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (dm_wr) wc++;
            b = busy;
            if (b) bc++;
            @(posedge clk);
            #1;
            rd = rdata; rv = rdata_valid; flt = fault;
            if (!b) break;
            @(negedge clk);
        end
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sx;
        logic [31:0] addr, wdata, rd;
        logic        rv, flt;
        int          bc, wc;
    } vec_t;

    vec_t tbl [$];

    initial begin
        logic [31:0] rd, erd;
        logic rv, flt, erv, eflt, we, sx;
        logic [1:0] size;
        logic [31:0] addr, wdata;
        int bc, wc, ebc, ewc;

        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h010, 32'h11223344, 32'h0, 1'b0, 1'b0, 0, 1});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 32'h11223344, 1'b1, 1'b0, 0, 0});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h020, 32'hAABBCCDD, 32'h0, 1'b0, 1'b0, 0, 1});
        tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h021, 32'h000000EE, 32'h0, 1'b0, 1'b0, 1, 1});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h020, 32'h0, 32'hAABBEEDD, 1'b1, 1'b0, 0, 0});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h021, 32'h0, 32'h000000EE, 1'b1, 1'b0, 0, 0});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h021, 32'h0, 32'hFFFFFFEE, 1'b1, 1'b0, 0, 0});
        tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h022, 32'h00008001, 32'h0, 1'b0, 1'b0, 1, 1});
        tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h022, 32'h0, 32'hFFFF8001, 1'b1, 1'b0, 0, 0});
        tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h022, 32'h0, 32'h00008001, 1'b1, 1'b0, 0, 0});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h023, 32'h0, 32'hFFFFFF80, 1'b1, 1'b0, 0, 0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h020, 32'h0, 32'h8001EEDD, 1'b1, 1'b0, 0, 0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h013, 32'h0, 32'h0, 1'b0, 1'b1, 0, 0});
        tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h011, 32'h0000FFFF, 32'h0, 1'b0, 1'b1, 0, 0});
        tbl.push_back('{1'b1, 2'd3, 1'b0, 32'h010, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 0, 0});
        tbl.push_back('{1'b0, 2'd3, 1'b0, 32'h010, 32'h0, 32'h0, 1'b0, 1'b1, 0, 0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 32'h11223344, 1'b1, 1'b0, 0, 0});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h10000004, 32'h00000005, 32'h0, 1'b0, 1'b0, 0, 1});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h004, 32'h0, 32'h00000005, 1'b1, 1'b0, 0, 0});

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", {31'b0, busy}, 32'h0);
        chk("reset rdata", rdata, 32'h0);
        chk("reset rdata_valid", {31'b0, rdata_valid}, 32'h0);
        chk("reset fault", {31'b0, fault}, 32'h0);
        chk("reset dm_wr", {31'b0, dm_wr}, 32'h0);
        chk("reset dm_din", dm_din, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) begin
            model(tbl[i].we, tbl[i].size, tbl[i].sx, tbl[i].addr, tbl[i].wdata, erd, erv, eflt, ebc, ewc);
            do_req(tbl[i].we, tbl[i].size, tbl[i].sx, tbl[i].addr, tbl[i].wdata, rd, rv, flt, bc, wc);
            chk($sformatf("vec%0d rdata_valid", i), {31'b0, rv}, {31'b0, tbl[i].rv});
            chk($sformatf("vec%0d fault", i), {31'b0, flt}, {31'b0, tbl[i].flt});
            chk($sformatf("vec%0d busy_cycles", i), 32'(bc), 32'(tbl[i].bc));
            chk($sformatf("vec%0d writes", i), 32'(wc), 32'(tbl[i].wc));
            if (tbl[i].rv) chk($sformatf("vec%0d rdata", i), rd, tbl[i].rd);
        end

        @(posedge clk);
        #1;
        chk("valid pulse ends", {31'b0, rdata_valid}, 32'h0);
        chk("rdata held", rdata, 32'h00000005);
        chk("mem @0x010 unchanged", dm[4], 32'h11223344);
        @(negedge clk);

        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signext = 1'b0;
        req_addr = 32'h030; req_wdata = 32'h0000005A;
        #1;
        chk("rst-merge busy", {31'b0, busy}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0;
        #1;
        chk("rst-merge dm_wr", {31'b0, dm_wr}, 32'h0);
        chk("rst-merge busy low", {31'b0, busy}, 32'h0);
        chk("rst-merge dm_din", dm_din, 32'h0);
        @(posedge clk);
        #1;
        chk("rst-merge rdata", rdata, 32'h0);
        chk("rst-merge fault", {31'b0, fault}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst-merge idle dm_wr", {31'b0, dm_wr}, 32'h0);
        chk("rst-merge mem @0x030", dm[12], 32'h0);
        @(negedge clk);
        model(1'b0, 2'd2, 1'b0, 32'h030, 32'h0, erd, erv, eflt, ebc, ewc);
        do_req(1'b0, 2'd2, 1'b0, 32'h030, 32'h0, rd, rv, flt, bc, wc);
        chk("rst-merge reload", rd, erd);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                #1;
                chk("idle dm_wr", {31'b0, dm_wr}, 32'h0);
                chk("idle busy", {31'b0, busy}, 32'h0);
                @(negedge clk);
            end
            we = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            sx = 1'($urandom_range(0, 1));
            addr = $urandom & 32'hFFFF_F03F;
            wdata = $urandom;
            model(we, size, sx, addr, wdata, erd, erv, eflt, ebc, ewc);
            do_req(we, size, sx, addr, wdata, rd, rv, flt, bc, wc);
            chk($sformatf("rnd%0d rdata_valid", n), {31'b0, rv}, {31'b0, erv});
            chk($sformatf("rnd%0d fault", n), {31'b0, flt}, {31'b0, eflt});
            chk($sformatf("rnd%0d busy_cycles", n), 32'(bc), 32'(ebc));
            chk($sformatf("rnd%0d writes", n), 32'(wc), 32'(ewc));
            if (erv) chk($sformatf("rnd%0d rdata", n), rd, erd);
        end

        for (int w = 0; w < 16; w++) chk($sformatf("final word %0d", w), dm[w], mword(w));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
